seq_divider_16bit: RTL

// - Multi-cycle unsigned 16-bit restoring divider. It is the inverse-direction

---
 rtl/div_pkg.sv | 21 ++
 rtl/cla_16bit.sv | 70 +++++++
 rtl/seq_divider_16bit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Divider controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Operand width and iteration counter width ($clog2(16)+1).
  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 5;

  // Counter value seen while the final quotient bit is being produced.
  function automatic logic [DIV_CNT_W-1:0] last_iter_count();
    return DIV_CNT_W'(DIV_WIDTH - 1);
  endfunction

endpackage : div_pkg

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups joined by a second
// lookahead level, so no carry ripples further than within one group.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  gc;
  logic [16:0] c;

  // Per-bit generate and propagate terms.
  always_comb begin
    g = a & b;
    p = a ^ b;
  end

  // Group generate/propagate for each 4-bit slice.
  always_comb begin
    gg = '0;
    pg = '0;
    for (int k = 0; k < 4; k++) begin
      pg[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Second-level lookahead: carry into each group straight from cin.
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (pg[0] & cin);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & cin);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
  end

  // Bit carries inside each group, expanded from the group carry-in.
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[16] = gc[4];
  end

  // Sum bits and carry out.
  always_comb begin
    sum  = p ^ c[15:0];
    cout = c[16];
  end

endmodule : cla_16bit

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned 16-bit restoring divider. One quotient bit per clock,
// with the trial subtraction done by a cla_16bit (divisor inverted, cin = 1).
module seq_divider_16bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // The adder is a fixed 16-bit block, so any other width cannot elaborate.
  if (WIDTH != 16) begin : g_bad_width
    $error("seq_divider_16bit: WIDTH must be 16");
  end
  if (CNT_W != $clog2(WIDTH) + 1) begin : g_bad_cnt_w
    $error("seq_divider_16bit: CNT_W must be $clog2(WIDTH)+1");
  end

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // Iteration datapath signals.
  logic             shift_msb;
  logic [WIDTH-1:0] shift_rem;
  logic [WIDTH-1:0] trial_b;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_cout;
  logic             trial_ok;
  logic [WIDTH-1:0] iter_rem;
  logic [WIDTH-1:0] iter_q;

  // Shift {rem, q} left one place; the bit leaving rem is the 17th bit.
  always_comb begin
    shift_msb = rem_q[WIDTH-1];
    shift_rem = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
    trial_b   = ~divisor_q;
  end

  cla_16bit u_trial_sub (
    .a    (shift_rem),
    .b    (trial_b),
    .cin  (1'b1),
    .sum  (trial_diff),
    .cout (trial_cout)
  );

  // Restore-or-keep decision: the subtraction fits when the dropped msb was
  // set or the adder produced no borrow (carry out high).
  always_comb begin
    trial_ok = shift_msb | trial_cout;
    if (trial_ok) begin
      iter_rem = trial_diff;
      iter_q   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      iter_rem = shift_rem;
      iter_q   = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and register-update logic for the controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          divisor_d = divisor;
          q_d       = dividend;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = (divisor == '0) ? ZERO : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = iter_rem;
        q_d   = iter_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last_iter_count()) begin
          state_d     = DONE;
          quotient_d  = iter_q;
          remainder_d = iter_rem;
          dbz_d       = 1'b0;
        end
      end
      ZERO: begin
        state_d     = DONE;
        quotient_d  = '1;
        remainder_d = q_q;
        dbz_d       = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Status outputs decode straight from the state; results from registers.
  always_comb begin
    busy        = (state_q == CALC);
    done        = (state_q == DONE);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule : seq_divider_16bit
